// File: rtl/decode_stage_if.sv
// ---------------------------------------------------------------------------
// decode_stage_if
//
// Bundles every non-clock/reset signal of the MIPS decode stage:
//   fetch side      : InstrD, PCD, PCPlus4D
//   hazard unit     : flush_e (in), RsD/RtD (out)
//   writeback side  : RegWriteW, WriteRegW, ResultW
//   ID/EX outputs   : control bits, ALUControlE, RD1E/RD2E, RsE/RtE/RdE,
//                     SignImmE, PCE, PCPlus4E
//
// modport slave  : the decode stage itself
// modport master : whatever drives the stage (pipeline top or testbench)
// ---------------------------------------------------------------------------
interface decode_stage_if;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        flush_e;
    logic        RegWriteW;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;

    logic [4:0]  RsD;
    logic [4:0]  RtD;

    logic        RegWriteE;
    logic        MemtoRegE;
    logic        MemWriteE;
    logic        BranchE;
    logic        JumpE;
    logic        ALUSrcE;
    logic        RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [4:0]  RsE;
    logic [4:0]  RtE;
    logic [4:0]  RdE;
    logic [31:0] SignImmE;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;

    modport slave (
        input  InstrD, PCD, PCPlus4D, flush_e, RegWriteW, WriteRegW, ResultW,
        output RsD, RtD,
        output RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ALUSrcE, RegDstE,
        output ALUControlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCE, PCPlus4E
    );

    modport master (
        output InstrD, PCD, PCPlus4D, flush_e, RegWriteW, WriteRegW, ResultW,
        input  RsD, RtD,
        input  RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE, ALUSrcE, RegDstE,
        input  ALUControlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Instruction-decode stage of a five-stage MIPS pipeline. Decodes the main
// control bits from the opcode/funct, reads the 32x32 register file,
// sign-extends the immediate and registers everything into ID/EX. Also
// hosts the register-file write port used by writeback.
//
// Ports:
//   clk     : pipeline clock, rising edge
//   rst     : asynchronous active-high reset (clears ID/EX and all registers)
//   dec_io  : decode_stage_if.slave carrying fetch inputs, writeback port,
//             flush_e, the combinational RsD/RtD and all registered E outputs
//
// Parameters:
//   NREG     : register-file depth (fixed at 32, 5-bit index)
//   RESET_PC : value loaded into PCE/PCPlus4E on reset or flush
//
// Build option:
//   DECODE_WB_BYPASS_EN : when defined, a writeback to Rs/Rt in the same
//                         cycle is forwarded into the read, so ID/EX picks up
//                         the new value at the edge of the write. When not
//                         defined, the pre-write value is captured.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int unsigned NREG     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave dec_io
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    function automatic logic signed [31:0] sign_extend16(input logic signed [15:0] imm);
        return 32'(imm);
    endfunction

    // Instruction fields
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_shamt;

    assign opcode       = dec_io.InstrD[31:26];
    assign rs           = dec_io.InstrD[25:21];
    assign rt           = dec_io.InstrD[20:16];
    assign rd           = dec_io.InstrD[15:11];
    assign funct        = dec_io.InstrD[5:0];
    assign unused_shamt = ^dec_io.InstrD[10:6];

    assign dec_io.RsD = rs;
    assign dec_io.RtD = rt;

    // Main decoder
    logic       reg_write_dec;
    logic       memto_reg_dec;
    logic       mem_write_dec;
    logic       branch_dec;
    logic       jump_dec;
    logic       alu_src_dec;
    logic       reg_dst_dec;
    logic [2:0] alu_ctrl_dec;

    always_comb begin
        reg_write_dec = 1'b0;
        memto_reg_dec = 1'b0;
        mem_write_dec = 1'b0;
        branch_dec    = 1'b0;
        jump_dec      = 1'b0;
        alu_src_dec   = 1'b0;
        reg_dst_dec   = 1'b0;
        alu_ctrl_dec  = 3'b000;
        unique case (opcode)
            OP_RTYPE: begin
                // An unsupported funct leaves every control at 0, including
                // RegWrite/RegDst, so it behaves as a bubble downstream.
                unique case (funct)
                    FN_ADD: begin reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_ctrl_dec = ALU_ADD; end
                    FN_SUB: begin reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_ctrl_dec = ALU_SUB; end
                    FN_AND: begin reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_ctrl_dec = ALU_AND; end
                    FN_OR:  begin reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_ctrl_dec = ALU_OR;  end
                    FN_SLT: begin reg_write_dec = 1'b1; reg_dst_dec = 1'b1; alu_ctrl_dec = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_LW: begin
                reg_write_dec = 1'b1;
                memto_reg_dec = 1'b1;
                alu_src_dec   = 1'b1;
                alu_ctrl_dec  = ALU_ADD;
            end
            OP_SW: begin
                mem_write_dec = 1'b1;
                alu_src_dec   = 1'b1;
                alu_ctrl_dec  = ALU_ADD;
            end
            OP_BEQ: begin
                branch_dec   = 1'b1;
                alu_ctrl_dec = ALU_SUB;
            end
            OP_ADDI: begin
                reg_write_dec = 1'b1;
                alu_src_dec   = 1'b1;
                alu_ctrl_dec  = ALU_ADD;
            end
            OP_J: begin
                jump_dec = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file: combinational read, write on rising edge, r0 hardwired
    logic [31:0] rf_q [NREG];
    logic [31:0] rf_d [NREG];
    logic        wb_we;
    logic [31:0] rd1;
    logic [31:0] rd2;

    assign wb_we = dec_io.RegWriteW && (dec_io.WriteRegW != 5'd0);

    always_comb begin
        rf_d = rf_q;
        if (wb_we) begin
            rf_d[dec_io.WriteRegW] = dec_io.ResultW;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    always_comb begin
        rd1 = (rs == 5'd0) ? 32'h0 : rf_q[rs];
        rd2 = (rt == 5'd0) ? 32'h0 : rf_q[rt];
`ifdef DECODE_WB_BYPASS_EN
        // wb_we already excludes index 0, so r0 still reads as zero.
        if (wb_we && (dec_io.WriteRegW == rs)) rd1 = dec_io.ResultW;
        if (wb_we && (dec_io.WriteRegW == rt)) rd2 = dec_io.ResultW;
`endif
    end

    // ID/EX next-state: decoded values, or a bubble when flushed
    logic        reg_write_d, memto_reg_d, mem_write_d, branch_d;
    logic        jump_d, alu_src_d, reg_dst_d;
    logic [2:0]  alu_ctrl_d;
    logic [31:0] rd1_d, rd2_d, sign_imm_d, pc_d, pc_plus4_d;
    logic [4:0]  rs_d, rt_d, rd_d;

    always_comb begin
        reg_write_d = reg_write_dec;
        memto_reg_d = memto_reg_dec;
        mem_write_d = mem_write_dec;
        branch_d    = branch_dec;
        jump_d      = jump_dec;
        alu_src_d   = alu_src_dec;
        reg_dst_d   = reg_dst_dec;
        alu_ctrl_d  = alu_ctrl_dec;
        rd1_d       = rd1;
        rd2_d       = rd2;
        rs_d        = rs;
        rt_d        = rt;
        rd_d        = rd;
        sign_imm_d  = sign_extend16(dec_io.InstrD[15:0]);
        pc_d        = dec_io.PCD;
        pc_plus4_d  = dec_io.PCPlus4D;
        if (dec_io.flush_e) begin
            reg_write_d = 1'b0;
            memto_reg_d = 1'b0;
            mem_write_d = 1'b0;
            branch_d    = 1'b0;
            jump_d      = 1'b0;
            alu_src_d   = 1'b0;
            reg_dst_d   = 1'b0;
            alu_ctrl_d  = 3'b000;
            rd1_d       = 32'h0;
            rd2_d       = 32'h0;
            rs_d        = 5'd0;
            rt_d        = 5'd0;
            rd_d        = 5'd0;
            sign_imm_d  = 32'h0;
            pc_d        = RESET_PC;
            pc_plus4_d  = RESET_PC;
        end
    end

    // ---- ID/EX pipeline register boundary ----
    logic        reg_write_q, memto_reg_q, mem_write_q, branch_q;
    logic        jump_q, alu_src_q, reg_dst_q;
    logic [2:0]  alu_ctrl_q;
    logic [31:0] rd1_q, rd2_q, sign_imm_q, pc_q, pc_plus4_q;
    logic [4:0]  rs_q, rt_q, rd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            jump_q      <= 1'b0;
            alu_src_q   <= 1'b0;
            reg_dst_q   <= 1'b0;
            alu_ctrl_q  <= 3'b000;
            rd1_q       <= 32'h0;
            rd2_q       <= 32'h0;
            rs_q        <= 5'd0;
            rt_q        <= 5'd0;
            rd_q        <= 5'd0;
            sign_imm_q  <= 32'h0;
            pc_q        <= RESET_PC;
            pc_plus4_q  <= RESET_PC;
        end else begin
            reg_write_q <= reg_write_d;
            memto_reg_q <= memto_reg_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            jump_q      <= jump_d;
            alu_src_q   <= alu_src_d;
            reg_dst_q   <= reg_dst_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            sign_imm_q  <= sign_imm_d;
            pc_q        <= pc_d;
            pc_plus4_q  <= pc_plus4_d;
        end
    end

    assign dec_io.RegWriteE   = reg_write_q;
    assign dec_io.MemtoRegE   = memto_reg_q;
    assign dec_io.MemWriteE   = mem_write_q;
    assign dec_io.BranchE     = branch_q;
    assign dec_io.JumpE       = jump_q;
    assign dec_io.ALUSrcE     = alu_src_q;
    assign dec_io.RegDstE     = reg_dst_q;
    assign dec_io.ALUControlE = alu_ctrl_q;
    assign dec_io.RD1E        = rd1_q;
    assign dec_io.RD2E        = rd2_q;
    assign dec_io.RsE         = rs_q;
    assign dec_io.RtE         = rt_q;
    assign dec_io.RdE         = rd_q;
    assign dec_io.SignImmE    = sign_imm_q;
    assign dec_io.PCE         = pc_q;
    assign dec_io.PCPlus4E    = pc_plus4_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage: directed and random checks of decode_stage against a
// table-driven reference model with a shadow register file.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if dif ();

    decode_stage #(.NREG(32), .RESET_PC(RPC)) dut (
        .clk    (clk),
        .rst    (rst),
        .dec_io (dif)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       rw, m2r, mw, br, jp, asrc, rdst;
        logic [2:0] alu;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic       use_fn;
        logic [5:0] fn;
        ctrl_t      c;
    } rule_t;

    typedef struct {
        ctrl_t       c;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs, rt, rd;
    } exp_t;

    rule_t       rules [$];
    logic [31:0] mrf [32];

    // Decode table: {RegWrite,MemtoReg,MemWrite,Branch,Jump,ALUSrc,RegDst,ALU}
    task automatic add_rule(input logic [5:0] op, input logic use_fn, input logic [5:0] fn,
                            input logic [9:0] bits);
        rule_t r;
        r.op = op; r.use_fn = use_fn; r.fn = fn; r.c = bits;
        rules.push_back(r);
    endtask

    function automatic ctrl_t model_ctrl(input logic [31:0] ins);
        foreach (rules[i]) begin
            if (rules[i].op == ins[31:26] && (!rules[i].use_fn || rules[i].fn == ins[5:0]))
                return rules[i].c;
        end
        return '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wr, input logic [31:0] res);
        if (idx == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
        if (we && wr == idx) return res;
`endif
        return mrf[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".RegWriteE"},   32'(dif.RegWriteE),   32'(e.c.rw));
        chk({tag, ".MemtoRegE"},   32'(dif.MemtoRegE),   32'(e.c.m2r));
        chk({tag, ".MemWriteE"},   32'(dif.MemWriteE),   32'(e.c.mw));
        chk({tag, ".BranchE"},     32'(dif.BranchE),     32'(e.c.br));
        chk({tag, ".JumpE"},       32'(dif.JumpE),       32'(e.c.jp));
        chk({tag, ".ALUSrcE"},     32'(dif.ALUSrcE),     32'(e.c.asrc));
        chk({tag, ".RegDstE"},     32'(dif.RegDstE),     32'(e.c.rdst));
        chk({tag, ".ALUControlE"}, 32'(dif.ALUControlE), 32'(e.c.alu));
        chk({tag, ".RD1E"},        dif.RD1E,             e.rd1);
        chk({tag, ".RD2E"},        dif.RD2E,             e.rd2);
        chk({tag, ".RsE"},         32'(dif.RsE),         32'(e.rs));
        chk({tag, ".RtE"},         32'(dif.RtE),         32'(e.rt));
        chk({tag, ".RdE"},         32'(dif.RdE),         32'(e.rd));
        chk({tag, ".SignImmE"},    dif.SignImmE,         e.imm);
        chk({tag, ".PCE"},         dif.PCE,              e.pc);
        chk({tag, ".PCPlus4E"},    dif.PCPlus4E,         e.pc4);
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        e.c = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
        e.rs = '0; e.rt = '0; e.rd = '0;
        e.pc = RPC; e.pc4 = RPC;
        check_outputs(tag, e);
    endtask

    // One pipeline cycle: drive, check RsD/RtD, clock, check ID/EX contents.
    task automatic step(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                        input logic fl, input logic we, input logic [4:0] wr,
                        input logic [31:0] res);
        exp_t e;
        dif.InstrD    = instr;
        dif.PCD       = pc;
        dif.PCPlus4D  = pc + 32'd4;
        dif.flush_e   = fl;
        dif.RegWriteW = we;
        dif.WriteRegW = wr;
        dif.ResultW   = res;
        #1;
        chk({tag, ".RsD"}, 32'(dif.RsD), 32'(instr[25:21]));
        chk({tag, ".RtD"}, 32'(dif.RtD), 32'(instr[20:16]));
        if (fl) begin
            e.c = '0; e.rd1 = '0; e.rd2 = '0; e.imm = '0;
            e.rs = '0; e.rt = '0; e.rd = '0;
            e.pc = RPC; e.pc4 = RPC;
        end else begin
            e.c   = model_ctrl(instr);
            e.rd1 = model_read(instr[25:21], we, wr, res);
            e.rd2 = model_read(instr[20:16], we, wr, res);
            e.imm = {{16{instr[15]}}, instr[15:0]};
            e.rs  = instr[25:21];
            e.rt  = instr[20:16];
            e.rd  = instr[15:11];
            e.pc  = pc;
            e.pc4 = pc + 32'd4;
        end
        @(posedge clk);
        if (we && wr != 5'd0) mrf[wr] = res;
        #1;
        check_outputs(tag, e);
    endtask

    localparam logic [31:0] ADD_10_8_9 = 32'h01095020;
    localparam logic [31:0] NOP_INSTR  = 32'h00000000;

    initial begin
        logic [5:0]  ops [7];
        logic [5:0]  fns [6];
        logic [31:0] r, instr;
        logic [5:0]  op, fn;
        logic [4:0]  wr;

        add_rule(6'b000000, 1'b1, 6'b100000, {7'b1000001, 3'b010});
        add_rule(6'b000000, 1'b1, 6'b100010, {7'b1000001, 3'b110});
        add_rule(6'b000000, 1'b1, 6'b100100, {7'b1000001, 3'b000});
        add_rule(6'b000000, 1'b1, 6'b100101, {7'b1000001, 3'b001});
        add_rule(6'b000000, 1'b1, 6'b101010, {7'b1000001, 3'b111});
        add_rule(6'b100011, 1'b0, 6'b0,      {7'b1100010, 3'b010});
        add_rule(6'b101011, 1'b0, 6'b0,      {7'b0010010, 3'b010});
        add_rule(6'b000100, 1'b0, 6'b0,      {7'b0001000, 3'b110});
        add_rule(6'b001000, 1'b0, 6'b0,      {7'b1000010, 3'b010});
        add_rule(6'b000010, 1'b0, 6'b0,      {7'b0000100, 3'b000});
        foreach (mrf[i]) mrf[i] = 32'h0;

        rst = 1'b1;
        dif.InstrD = '0; dif.PCD = '0; dif.PCPlus4D = '0; dif.flush_e = 1'b0;
        dif.RegWriteW = 1'b0; dif.WriteRegW = '0; dif.ResultW = '0;
        #2 check_reset("por");
        @(posedge clk); #1 check_reset("por_edge");
        #3 rst = 1'b0;

        // Three instructions, one writing r8, then async reset between edges
        step("pre1", 32'h8D09FFFC, 32'h100, 1'b0, 1'b1, 5'd8, 32'h0000_0077);
        step("pre2", ADD_10_8_9,   32'h104, 1'b0, 1'b0, 5'd0, 32'h0);
        step("pre3", 32'h10850003, 32'h108, 1'b0, 1'b0, 5'd0, 32'h0);
        #2 rst = 1'b1;
        #1 check_reset("async_rst");
        foreach (mrf[i]) mrf[i] = 32'h0;
        @(posedge clk); #1 check_reset("rst_hold");
        #2 rst = 1'b0;
        step("rst_r8", ADD_10_8_9, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("rst_r8_zero", dif.RD1E, 32'h0);

        // Write then read
        step("wr_r8", NOP_INSTR, 32'h204, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF);
        step("rd_r8", ADD_10_8_9, 32'h208, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t2_rd1", dif.RD1E, 32'hDEADBEEF);
        chk("t2_regwrite", 32'(dif.RegWriteE), 32'd1);
        chk("t2_regdst", 32'(dif.RegDstE), 32'd1);
        chk("t2_alu", 32'(dif.ALUControlE), 32'd2);
        chk("t2_rd", 32'(dif.RdE), 32'd10);

        // Same-edge write/read of r8
        step("set_r8", NOP_INSTR, 32'h20C, 1'b0, 1'b1, 5'd8, 32'h1);
        step("hazard", ADD_10_8_9, 32'h210, 1'b0, 1'b1, 5'd8, 32'h5);
`ifdef DECODE_WB_BYPASS_EN
        chk("t3_bypass", dif.RD1E, 32'h5);
`else
        chk("t3_nobypass", dif.RD1E, 32'h1);
`endif
        step("hazard_after", ADD_10_8_9, 32'h214, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t3_after", dif.RD1E, 32'h5);

        // lw
        step("lw", 32'h8D09FFFC, 32'h218, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t4_imm", dif.SignImmE, 32'hFFFFFFFC);
        chk("t4_m2r", 32'(dif.MemtoRegE), 32'd1);
        chk("t4_asrc", 32'(dif.ALUSrcE), 32'd1);
        chk("t4_rdst", 32'(dif.RegDstE), 32'd0);
        chk("t4_rt", 32'(dif.RtE), 32'd9);
        chk("t4_rs", 32'(dif.RsE), 32'd8);

        // Flush, then r0 write discarded
        step("sw_flush", 32'hAD090004, 32'h21C, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("t5_memwrite", 32'(dif.MemWriteE), 32'd0);
        step("wr_r0", NOP_INSTR, 32'h220, 1'b0, 1'b1, 5'd0, 32'h1234);
        step("rd_r0", 32'h00005020, 32'h224, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t5_r0", dif.RD1E, 32'h0);

        // Write concurrent with flush: write lands, ID/EX is a bubble
        step("wr_flush", ADD_10_8_9, 32'h228, 1'b1, 1'b1, 5'd9, 32'hCAFE_0009);
        step("rd_r9", ADD_10_8_9, 32'h22C, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("wf_r9", dif.RD2E, 32'hCAFE_0009);

        // Illegal opcode and R-type funct 0
        step("ill_op", 32'hFC000000, 32'h230, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t6_pc4_op", dif.PCPlus4E, 32'h234);
        step("ill_fn", 32'h01095000, 32'h234, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("t6_regwrite_fn", 32'(dif.RegWriteE), 32'd0);
        chk("t6_pc4_fn", dif.PCPlus4E, 32'h238);

        // Random traffic
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 300; n++) begin
            r  = $urandom();
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom());
            fn = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) fn = 6'($urandom());
            instr = {op, r[25:6], fn};
            wr = 5'($urandom());
            if ($urandom_range(0, 3) == 0) wr = instr[25:21];
            step("rand", instr, $urandom() & 32'hFFFF_FFFC,
                 ($urandom_range(0, 9) == 0), 1'($urandom()), wr, $urandom());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
